// File: rtl/quad_enc_pkg.sv
// Shared step type and the x4 quadrature transition decoder.
// Pure combinational helpers: no latency, no flow control.
package quad_enc_pkg;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_FWD,
      STEP_REV,
      STEP_ERR
   } step_t;

   // {A,B} forward order is 00 -> 10 -> 11 -> 01 -> 00
   function automatic step_t decode_step(input logic [1:0] old_ab, input logic [1:0] new_ab);
      step_t s;
      case ({old_ab, new_ab})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_FWD;
         4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: s = STEP_REV;
         4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: s = STEP_ERR;
         default:                                s = STEP_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: sync, glitch filter, x4 decode, position, windowed speed, sticky err.
// Latency FILT_LEN+3 clk from raw edge to position; free-running, no backpressure.
module quad_enc_channel
   import quad_enc_pkg::*;
#(
   parameter int POS_W    = 32,
   parameter int SPD_W    = 16,
   parameter int FILT_LEN = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enc_a,
   input  logic                    enc_b,
   input  logic                    clear_pos,
   input  logic                    err_clear,
   input  logic                    win_end,
   output logic signed [POS_W-1:0] position,
   output logic signed [SPD_W-1:0] speed,
   output logic                    err
);

   localparam int CNT_W = 4;
   localparam int PRIME = FILT_LEN + 2;
   localparam logic signed [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
   localparam logic signed [SPD_W-1:0] SPD_MIN = -SPD_MAX;

   logic [1:0]       sync1, sync2, filt, prev_ab;
   logic [CNT_W-1:0] fcnt [2];
   logic [4:0]       prime_cnt;
   logic             primed;
   step_t            step;
   logic signed [POS_W-1:0] pos_delta;
   logic signed [SPD_W-1:0] acc, acc_next;

   // bit 1 = A, bit 0 = B; each bit filtered independently
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         filt    <= '0;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         sync1 <= {enc_a, enc_b};
         sync2 <= sync1;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CNT_W'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Suppress counting until the pipeline has settled on the post-reset input level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_cnt <= '0;
         primed    <= 1'b0;
         prev_ab   <= '0;
      end else begin
         prev_ab <= filt;
         if (!primed) begin
            if (prime_cnt == 5'(PRIME)) primed <= 1'b1;
            prime_cnt <= prime_cnt + 5'd1;
         end
      end
   end

   always_comb begin
      step      = primed ? decode_step(prev_ab, filt) : STEP_NONE;
      pos_delta = '0;
      acc_next  = acc;
      case (step)
         STEP_FWD: begin
            pos_delta = POS_W'(1);
            if (acc != SPD_MAX) acc_next = acc + SPD_W'(1);
         end
         STEP_REV: begin
            pos_delta = '1;
            if (acc != SPD_MIN) acc_next = acc - SPD_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         position <= '0;
         acc      <= '0;
         speed    <= '0;
         err      <= 1'b0;
      end else begin
         position <= clear_pos ? pos_delta : position + pos_delta;
         if (win_end) begin
            speed <= acc_next;
            acc   <= '0;
         end else begin
            acc <= acc_next;
         end
         if (step == STEP_ERR)  err <= 1'b1;
         else if (err_clear)    err <= 1'b0;
      end
   end

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of N_CH quadrature decoders sharing one speed window counter.
// Position latency FILT_LEN+3 clk; speed_valid pulses the cycle after each window end; no backpressure.
module quad_encoder_bank
   import quad_enc_pkg::*;
#(
   parameter int N_CH       = 2,
   parameter int POS_W      = 32,
   parameter int SPD_W      = 16,
   parameter int WIN_CYCLES = 250_000,
   parameter int FILT_LEN   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         enc_a,
   input  logic [N_CH-1:0]         enc_b,
   input  logic [N_CH-1:0]         clear_pos,
   input  logic [N_CH-1:0]         err_clear,
   output logic [N_CH*POS_W-1:0]   position,
   output logic [N_CH*SPD_W-1:0]   speed,
   output logic                    speed_valid,
   output logic [N_CH-1:0]         err
);

   localparam int CW = $clog2(WIN_CYCLES);

   logic [CW-1:0] win_cnt;
   logic          win_end;

   assign win_end = (win_cnt == CW'(WIN_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt     <= '0;
         speed_valid <= 1'b0;
      end else begin
         speed_valid <= win_end;
         win_cnt     <= win_end ? '0 : win_cnt + CW'(1);
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      quad_enc_channel #(
         .POS_W    (POS_W),
         .SPD_W    (SPD_W),
         .FILT_LEN (FILT_LEN)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .enc_a     (enc_a[k]),
         .enc_b     (enc_b[k]),
         .clear_pos (clear_pos[k]),
         .err_clear (err_clear[k]),
         .win_end   (win_end),
         .position  (position[k*POS_W +: POS_W]),
         .speed     (speed[k*SPD_W +: SPD_W]),
         .err       (err[k])
      );
   end

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench: main 2-channel bank plus a 1-channel SPD_W=4 bank sharing channel-0 stimulus.
module tb_quad_encoder_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  enc_a, enc_b, clear_pos, err_clear;
   logic [63:0] position;
   logic [31:0] speed;
   logic        speed_valid;
   logic [1:0]  err;

   logic [0:0]  zero1 = 1'b0;
   logic [0:0]  zero2 = 1'b0;
   logic [31:0] position1;
   logic [3:0]  speed1;
   logic        speed_valid1;
   logic [0:0]  err1;

   int n_assert = 0;
   int n_fail   = 0;
   int n;

   always #5 clk = ~clk;

   quad_encoder_bank #(
      .N_CH(2), .POS_W(32), .SPD_W(16), .WIN_CYCLES(100), .FILT_LEN(3)
   ) dut0 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .clear_pos(clear_pos), .err_clear(err_clear),
      .position(position), .speed(speed), .speed_valid(speed_valid), .err(err)
   );

   quad_encoder_bank #(
      .N_CH(1), .POS_W(32), .SPD_W(4), .WIN_CYCLES(100), .FILT_LEN(3)
   ) dut1 (
      .clk(clk), .reset(reset), .enc_a(enc_a[0:0]), .enc_b(enc_b[0:0]),
      .clear_pos(zero1), .err_clear(zero2),
      .position(position1), .speed(speed1), .speed_valid(speed_valid1), .err(err1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_sv(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!speed_valid && cnt < 300);
      check("sv_wait", {63'd0, speed_valid}, 64'd1);
   endtask

   function automatic logic [1:0] fwd_of(input logic [1:0] v);
      case (v)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] rev_of(input logic [1:0] v);
      case (v)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic set_ab(input logic [1:0] v);
      enc_a[0] = v[1];
      enc_b[0] = v[0];
   endtask

   task automatic step(input bit fwd);
      logic [1:0] cur;
      cur = {enc_a[0], enc_b[0]};
      set_ab(fwd ? fwd_of(cur) : rev_of(cur));
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; enc_a = '0; enc_b = '0; clear_pos = '0; err_clear = '0;
      repeat (3) @(negedge clk);
      check("rst_position", position, 64'd0);
      check("rst_speed", {32'd0, speed}, 64'd0);
      check("rst_err", {62'd0, err}, 64'd0);
      check("rst_speed_valid", {63'd0, speed_valid}, 64'd0);
      check("rst_speed_spd4", {60'd0, speed1}, 64'd0);

      reset = 1'b0;
      wait_sv(n);
      check("first_window_len", 64'(n), 64'd100);
      check("idle_position", position, 64'd0);

      // 8 forward steps on channel 0
      repeat (8) step(1'b1);
      repeat (8) @(negedge clk);
      check("fwd8_pos0", {32'd0, position[31:0]}, 64'd8);
      check("fwd8_pos1", {32'd0, position[63:32]}, 64'd0);
      check("fwd8_pos_spd4", {32'd0, position1}, 64'd8);
      wait_sv(n);
      check("fwd8_speed0", {48'd0, speed[15:0]}, 64'd8);
      check("fwd8_speed1", {48'd0, speed[31:16]}, 64'd0);
      check("fwd8_speed_sat4", {60'd0, speed1}, 64'd7);
      @(negedge clk);
      check("sv_one_cycle", {63'd0, speed_valid}, 64'd0);
      check("speed_hold", {48'd0, speed[15:0]}, 64'd8);

      // clear, then 5 forward + 7 reverse in one window
      clear_pos[0] = 1'b1;
      @(negedge clk);
      clear_pos[0] = 1'b0;
      check("clear_pos0", {32'd0, position[31:0]}, 64'd0);
      repeat (5) step(1'b1);
      repeat (7) step(1'b0);
      repeat (8) @(negedge clk);
      check("fr_pos0", {32'd0, position[31:0]}, 64'hFFFF_FFFE);
      check("fr_pos_spd4", {32'd0, position1}, 64'd6);
      wait_sv(n);
      check("fr_speed0", {48'd0, speed[15:0]}, 64'hFFFE);
      check("fr_speed_spd4", {60'd0, speed1}, 64'hE);

      // 2-cycle glitch on A (ab is 11 here), then a held forward change
      enc_a[0] = 1'b0;
      repeat (2) @(negedge clk);
      enc_a[0] = 1'b1;
      repeat (10) @(negedge clk);
      check("glitch_pos0", {32'd0, position[31:0]}, 64'hFFFF_FFFE);
      enc_a[0] = 1'b0;
      repeat (5) @(negedge clk);
      check("lat5_pos0", {32'd0, position[31:0]}, 64'hFFFF_FFFE);
      @(negedge clk);
      check("lat6_pos0", {32'd0, position[31:0]}, 64'hFFFF_FFFF);

      // A and B toggle together: 01 -> 10
      enc_a[0] = 1'b1;
      enc_b[0] = 1'b0;
      repeat (10) @(negedge clk);
      check("illegal_pos0", {32'd0, position[31:0]}, 64'hFFFF_FFFF);
      check("illegal_err", {62'd0, err}, 64'd1);
      check("illegal_err_spd4", {63'd0, err1}, 64'd1);
      err_clear[0] = 1'b1;
      @(negedge clk);
      err_clear[0] = 1'b0;
      check("err_cleared", {62'd0, err}, 64'd0);

      // wrap from the largest positive position
      force dut0.g_ch[0].u_ch.position = 32'h7FFF_FFFF;
      @(negedge clk);
      release dut0.g_ch[0].u_ch.position;
      step(1'b1);
      repeat (6) @(negedge clk);
      check("wrap_pos0", {32'd0, position[31:0]}, 64'h8000_0000);

      // 10 forward steps in one window: SPD_W=4 saturates at +7
      wait_sv(n);
      repeat (10) step(1'b1);
      wait_sv(n);
      check("fwd10_speed0", {48'd0, speed[15:0]}, 64'd10);
      check("fwd10_speed_sat4", {60'd0, speed1}, 64'd7);
      check("fwd10_pos0", {32'd0, position[31:0]}, 64'h8000_000A);

      // clear_pos coincident with a forward step (ab is 00 here)
      set_ab(2'b10);
      repeat (5) @(negedge clk);
      clear_pos[0] = 1'b1;
      @(negedge clk);
      clear_pos[0] = 1'b0;
      check("clear_step_pos0", {32'd0, position[31:0]}, 64'd1);

      // reset in the middle of a window
      wait_sv(n);
      repeat (49) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_position", position, 64'd0);
      check("midrst_err_spd4", {63'd0, err1}, 64'd0);
      check("midrst_speed", {32'd0, speed}, 64'd0);
      reset = 1'b0;
      wait_sv(n);
      check("midrst_window_len", 64'(n), 64'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_encoder_bank.md
QUAD_ENCODER_BANK -- requirements
Module: quad_encoder_bank

Interface
REQ-001 The block SHALL have parameter N_CH, default 2: number of independent quadrature channels.
REQ-002 The block SHALL have parameter POS_W, default 32: signed position counter width.
REQ-003 The block SHALL have parameter SPD_W, default 16: signed speed word width.
REQ-004 The block SHALL have parameter WIN_CYCLES, default 250_000: speed measurement window in clk cycles, legal range 2 to 2^24.
REQ-005 The block SHALL have parameter FILT_LEN, default 3: consecutive equal samples required by the glitch filter, legal range 1 to 15.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock.
REQ-007 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port enc_a, input, N_CH bits: raw asynchronous A phase per channel.
REQ-009 The block SHALL have port enc_b, input, N_CH bits: raw asynchronous B phase per channel.
REQ-010 The block SHALL have port clear_pos, input, N_CH bits: synchronous per-channel position clear.
REQ-011 The block SHALL have port err_clear, input, N_CH bits: clears per-channel sticky error.
REQ-012 The block SHALL have port position, output, N_CH x POS_W bits: signed accumulated position, channel k at [k*POS_W +: POS_W].
REQ-013 The block SHALL have port speed, output, N_CH x SPD_W bits: signed net edge count of the last completed window.
REQ-014 The block SHALL have port speed_valid, output, 1 bit: one-cycle pulse when all speed words update.
REQ-015 The block SHALL have port err, output, N_CH bits: sticky illegal-transition flag.

Function
REQ-016 Each enc_a/enc_b bit SHALL pass a 2-FF synchroniser, then a filter whose output changes only after FILT_LEN consecutive equal synchronised samples.
REQ-017 Decode SHALL be x4: filtered {A,B} sequence 00->10->11->01->00 = +1 per step; the reverse sequence = -1; no change = 0.
REQ-018 A transition with both A and B changing in one cycle SHALL count 0 and set err[k]; err[k] SHALL hold until err_clear[k]. When set and clear coincide, set SHALL win.
REQ-019 Latency SHALL be exactly FILT_LEN+3 clk cycles from a stable raw input change to the position update.
REQ-020 Position SHALL wrap modulo 2^POS_W, two's complement; no saturation.
REQ-021 When clear_pos[k] and a step coincide, position[k] SHALL become the step value (-1, 0 or +1). clear_pos[k] SHALL NOT affect speed or err.
REQ-022 One shared window counter SHALL count 0..WIN_CYCLES-1. In the cycle it equals WIN_CYCLES-1, each channel accumulator, including that cycle's step, SHALL load into speed[k], and the accumulators SHALL restart at 0.
REQ-023 speed_valid SHALL assert for exactly the one cycle following the window end; speed SHALL hold between windows.
REQ-024 Window accumulators SHALL saturate at +(2^(SPD_W-1)-1) and -(2^(SPD_W-1)-1); the sign indicates direction.

Reset
REQ-025 On reset, position, speed, err, speed_valid, the accumulators and the window counter SHALL all be 0.
REQ-026 On reset, synchroniser and filter state SHALL be 0, and the first post-reset state SHALL be taken as reference without counting.
REQ-027 Reset mid-window SHALL discard the partial window; the first speed_valid SHALL follow WIN_CYCLES cycles after reset deassertion.

Structure
REQ-028 Package quad_enc_pkg SHALL hold the step type (enum: STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR) and the decode function mapping {old_ab,new_ab} to a step.
REQ-029 Sub-module quad_enc_channel (sync, filter, decode, position, accumulator, err) SHALL be instantiated N_CH times via generate; the window counter SHALL reside in the top level.

Verification
REQ-030 Bench SHALL cover: N_CH=2, FILT_LEN=3, WIN_CYCLES=100; 8 forward steps on channel 0 -> position[0]=8, position[1]=0, speed[0]=8 at the next speed_valid.
REQ-031 Bench SHALL cover: 5 forward then 7 reverse steps within one window -> position=-2, speed=-2.
REQ-032 Bench SHALL cover: a 2-cycle glitch on A -> no count. A 3-cycle level -> counted, with position changing exactly 6 cycles after the input change.
REQ-033 Bench SHALL cover: A and B toggled in the same cycle -> position unchanged, err[0]=1; after err_clear -> err[0]=0.
REQ-034 Bench SHALL cover: position preloaded to 0x7FFFFFFF plus one forward step -> 0x80000000. SPD_W=4 with 10 forward steps in one window -> speed=+7.
REQ-035 Bench SHALL cover: clear_pos in the same cycle as a forward step -> position=1. Reset at cycle 50 of a window -> speed_valid exactly 100 cycles after reset release.
